// File: rtl/pipelined_cla_adder_if.sv
// Handshake and data bundle for pipelined_cla_adder.
//   master : operand producer / result consumer (drives in_valid, a, b, cin, sub, out_ready)
//   slave  : the adder itself (drives in_ready, out_valid, sum, cout, ovf, zero)
interface pipelined_cla_adder_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             zero;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf, zero
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf, zero
   );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor.
// Operands are split into STAGES segments of SEG bits; stage k resolves segment k
// with 4-bit lookahead groups and a group-level lookahead carry, then registers
// the segment carry for stage k+1. The last stage register is the output register.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of pipelined_cla_adder_if
//           (in_valid/in_ready/a/b/cin/sub in, out_valid/out_ready/sum/cout/ovf/zero out)
module pipelined_cla_adder #(
   parameter int               WIDTH      = 32,
   parameter int               STAGES     = 4,
   parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   pipelined_cla_adder_if.slave  bus
);
   localparam int SEG = WIDTH / STAGES;
   localparam int NG  = SEG / 4;

   // Returns {carry_out, carry_into_msb, sum} for one SEG-bit segment.
   function automatic logic [SEG+1:0] seg_add(
      input logic [SEG-1:0] x,
      input logic [SEG-1:0] y,
      input logic           ci
   );
      logic [SEG-1:0] g;
      logic [SEG-1:0] p;
      logic [SEG-1:0] bc;
      logic [NG-1:0]  gg;
      logic [NG-1:0]  gp;
      logic [NG:0]    gc;
      logic           acc;
      logic           tp;
      g = x & y;
      p = x ^ y;
      for (int j = 0; j < NG; j++) begin
         gg[j] = g[4*j+3]
               | (p[4*j+3] & g[4*j+2])
               | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
         gp[j] = &p[4*j +: 4];
      end
      // Group carries as flat sum-of-products: every term of c(j+1) is built
      // directly from group G/P and the segment carry-in, no chaining through c(j).
      gc[0] = ci;
      for (int j = 0; j < NG; j++) begin
         acc = gg[j];
         tp  = gp[j];
         for (int i = j - 1; i >= 0; i--) begin
            acc = acc | (tp & gg[i]);
            tp  = tp & gp[i];
         end
         gc[j+1] = acc | (tp & ci);
      end
      for (int j = 0; j < NG; j++) begin
         bc[4*j]   = gc[j];
         bc[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
         bc[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
         bc[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                   | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
      end
      return {gc[NG], bc[SEG-1], p ^ bc};
   endfunction

   logic [STAGES-1:0] v_q;
   logic [STAGES-1:0] v_d;
   logic [STAGES-1:0] c_q;
   logic [STAGES-1:0] c_d;
   logic [WIDTH-1:0]  a_q   [STAGES];
   logic [WIDTH-1:0]  a_d   [STAGES];
   logic [WIDTH-1:0]  b_q   [STAGES];
   logic [WIDTH-1:0]  b_d   [STAGES];
   logic [WIDTH-1:0]  sum_q [STAGES];
   logic [WIDTH-1:0]  sum_d [STAGES];
   logic              ovf_q;
   logic              ovf_d;
   logic              zero_q;
   logic              zero_d;

   logic [STAGES-1:0] adv;
   logic [STAGES-1:0] v_src;
   logic [STAGES-1:0] c_src;
   logic [WIDTH-1:0]  a_src   [STAGES];
   logic [WIDTH-1:0]  b_src   [STAGES];
   logic [WIDTH-1:0]  sum_src [STAGES];
   logic [WIDTH-1:0]  sum_new [STAGES];
   logic [SEG+1:0]    seg_r   [STAGES];

   // A stage may load when it is empty or everything downstream of it moves.
   always_comb begin
      logic run;
      adv = '0;
      run = bus.out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         run    = run | ~v_q[k];
         adv[k] = run;
      end
   end

   assign bus.in_ready = adv[0];

   // Unprocessed operand bits are kept right-aligned, so every stage works on
   // bits [SEG-1:0] of its source and passes the rest on shifted down by SEG.
   always_comb begin
      v_src      = '0;
      c_src      = '0;
      v_src[0]   = bus.in_valid & adv[0];
      c_src[0]   = bus.sub | bus.cin;
      a_src[0]   = bus.a;
      b_src[0]   = bus.sub ? ~bus.b : bus.b;
      sum_src[0] = '0;
      for (int k = 1; k < STAGES; k++) begin
         v_src[k]   = v_q[k-1];
         c_src[k]   = c_q[k-1];
         a_src[k]   = a_q[k-1];
         b_src[k]   = b_q[k-1];
         sum_src[k] = sum_q[k-1];
      end

      v_d = v_q;
      c_d = c_q;
      for (int k = 0; k < STAGES; k++) begin
         seg_r[k]   = seg_add(a_src[k][SEG-1:0], b_src[k][SEG-1:0], c_src[k]);
         sum_new[k] = sum_src[k];
         sum_new[k][k*SEG +: SEG] = seg_r[k][SEG-1:0];
         a_d[k]   = a_q[k];
         b_d[k]   = b_q[k];
         sum_d[k] = sum_q[k];
         if (adv[k]) begin
            v_d[k]   = v_src[k];
            c_d[k]   = seg_r[k][SEG+1];
            a_d[k]   = a_src[k] >> SEG;
            b_d[k]   = b_src[k] >> SEG;
            sum_d[k] = sum_new[k];
         end
      end

      // Flags are registered alongside the final sum so they reset to 0
      // and stay frozen with the result during a stall.
      ovf_d  = ovf_q;
      zero_d = zero_q;
      if (adv[STAGES-1]) begin
         ovf_d  = seg_r[STAGES-1][SEG] ^ seg_r[STAGES-1][SEG+1];
         zero_d = (sum_new[STAGES-1] == '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q    <= '0;
         c_q    <= '0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]   <= RESET_DATA;
            b_q[k]   <= RESET_DATA;
            sum_q[k] <= RESET_DATA;
         end
      end else begin
         v_q    <= v_d;
         c_q    <= c_d;
         ovf_q  <= ovf_d;
         zero_q <= zero_d;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]   <= a_d[k];
            b_q[k]   <= b_d[k];
            sum_q[k] <= sum_d[k];
         end
      end
   end

   assign bus.out_valid = v_q[STAGES-1];
   assign bus.sum       = sum_q[STAGES-1];
   assign bus.cout      = c_q[STAGES-1];
   assign bus.ovf       = ovf_q;
   assign bus.zero      = zero_q;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed and streaming checks for pipelined_cla_adder (WIDTH=32, STAGES=4).
module tb_pipelined_cla_adder;
   localparam int WIDTH  = 32;
   localparam int STAGES = 4;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic        sub;
      logic [31:0] s;
      logic        co;
      logic        ov;
      logic        z;
   } vec_t;

   typedef struct packed {
      logic [31:0] s;
      logic        co;
      logic        ov;
      logic        z;
   } res_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   pipelined_cla_adder_if #(.WIDTH(WIDTH)) bus ();

   pipelined_cla_adder #(
      .WIDTH      (WIDTH),
      .STAGES     (STAGES),
      .RESET_DATA (32'h0)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic test_reset();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if ({bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.zero, bus.in_ready} !== {1'b0, 32'h0, 3'b000, 1'b1}) begin
         n_err++;
         $display("FAIL reset_state: got ov=%b sum=%h cout=%b ovf=%b zero=%b ir=%b, want ov=0 sum=00000000 cout=0 ovf=0 zero=0 ir=1",
                  bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.zero, bus.in_ready);
      end
      bus.out_ready = 1'b0;
      #1;
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_empty_ready: got in_ready=%b want 1", bus.in_ready);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_add();
      vec_t tbl[5];
      tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
      tbl[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
      tbl[2] = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{32'h00000001, 32'h00000002, 1'b1, 1'b0, 32'h00000004, 1'b0, 1'b0, 1'b0};
      tbl[4] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
      foreach (tbl[i]) begin
         int cyc;
         bus.a = tbl[i].a;  bus.b = tbl[i].b;  bus.cin = tbl[i].cin;  bus.sub = tbl[i].sub;
         bus.in_valid  = 1'b1;
         bus.out_ready = 1'b1;
         @(posedge clk);
         #1;
         bus.in_valid = 1'b0;
         bus.a = 32'hDEADBEEF;
         cyc = 0;
         while (!bus.out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
         end
         n_cmp++;
         if (cyc !== STAGES - 1) begin
            n_err++;
            $display("FAIL add_%0d latency: got %0d edges after accept, want %0d", i, cyc, STAGES - 1);
         end
         n_cmp++;
         if ({bus.sum, bus.cout, bus.ovf, bus.zero} !== {tbl[i].s, tbl[i].co, tbl[i].ov, tbl[i].z}) begin
            n_err++;
            $display("FAIL add_%0d result: got sum=%h cout=%b ovf=%b zero=%b, want sum=%h cout=%b ovf=%b zero=%b",
                     i, bus.sum, bus.cout, bus.ovf, bus.zero, tbl[i].s, tbl[i].co, tbl[i].ov, tbl[i].z);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_subtract();
      vec_t tbl[5];
      tbl[0] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
      tbl[3] = '{32'h12345678, 32'h12345678, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
      tbl[4] = '{32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
      foreach (tbl[i]) begin
         int cyc;
         bus.a = tbl[i].a;  bus.b = tbl[i].b;  bus.cin = tbl[i].cin;  bus.sub = tbl[i].sub;
         bus.in_valid  = 1'b1;
         bus.out_ready = 1'b1;
         @(posedge clk);
         #1;
         bus.in_valid = 1'b0;
         bus.sub = 1'b0;
         cyc = 0;
         while (!bus.out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
         end
         n_cmp++;
         if (cyc !== STAGES - 1) begin
            n_err++;
            $display("FAIL sub_%0d latency: got %0d edges after accept, want %0d", i, cyc, STAGES - 1);
         end
         n_cmp++;
         if ({bus.sum, bus.cout, bus.ovf, bus.zero} !== {tbl[i].s, tbl[i].co, tbl[i].ov, tbl[i].z}) begin
            n_err++;
            $display("FAIL sub_%0d result: got sum=%h cout=%b ovf=%b zero=%b, want sum=%h cout=%b ovf=%b zero=%b",
                     i, bus.sum, bus.cout, bus.ovf, bus.zero, tbl[i].s, tbl[i].co, tbl[i].ov, tbl[i].z);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_s[4];
      exp_s[0] = 32'h01010101;
      exp_s[1] = 32'h12121212;
      exp_s[2] = 32'h23232323;
      exp_s[3] = 32'h34343434;
      bus.out_ready = 1'b0;
      bus.sub = 1'b0;
      bus.cin = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.a = 32'h11111111 * i;
         bus.b = 32'h01010101;
         bus.in_valid = 1'b1;
         #1;
         n_cmp++;
         if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL fill_ready_%0d: got in_ready=%b want 1", i, bus.in_ready);
         end
         @(posedge clk);
         #1;
      end
      bus.a = 32'hFFFFFFFF;
      bus.b = 32'hFFFFFFFF;
      for (int h = 0; h < 2; h++) begin
         #1;
         n_cmp++;
         if ({bus.in_ready, bus.out_valid, bus.sum} !== {1'b0, 1'b1, exp_s[0]}) begin
            n_err++;
            $display("FAIL full_stall_%0d: got ir=%b ov=%b sum=%h, want ir=0 ov=1 sum=%h",
                     h, bus.in_ready, bus.out_valid, bus.sum, exp_s[0]);
         end
         @(posedge clk);
         #1;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL release_ready: got in_ready=%b want 1 in same cycle", bus.in_ready);
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if ({bus.out_valid, bus.sum} !== {1'b1, exp_s[i]}) begin
            n_err++;
            $display("FAIL drain_%0d: got ov=%b sum=%h, want ov=1 sum=%h", i, bus.out_valid, bus.sum, exp_s[i]);
         end
         @(posedge clk);
         #1;
      end
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL drain_empty: got out_valid=%b want 0", bus.out_valid);
      end
   endtask

   task automatic test_bubble();
      logic [3:0] exp_v[5];
      logic [3:0] exp_c[3];
      exp_v[0] = 4'b0001;  exp_v[1] = 4'b0010;  exp_v[2] = 4'b0100;
      exp_v[3] = 4'b1000;  exp_v[4] = 4'b0000;
      exp_c[0] = 4'b1010;  exp_c[1] = 4'b1100;  exp_c[2] = 4'b1100;
      bus.out_ready = 1'b1;
      bus.sub = 1'b0;  bus.cin = 1'b0;
      bus.a = 32'h00000003;  bus.b = 32'h00000004;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (dut.v_q !== exp_v[i]) begin
            n_err++;
            $display("FAIL bubble_walk_%0d: got stage valids=%b want %b", i, dut.v_q, exp_v[i]);
         end
         @(posedge clk);
         #1;
      end
      // second transaction slides into the gap behind a stalled result
      bus.out_ready = 1'b0;
      bus.a = 32'h00000001;  bus.b = 32'h00000001;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      bus.a = 32'h00000002;  bus.b = 32'h00000002;
      bus.in_valid = 1'b1;
      #1;
      n_cmp++;
      if ({bus.in_ready, dut.v_q, bus.sum} !== {1'b1, 4'b1000, 32'h00000002}) begin
         n_err++;
         $display("FAIL collapse_entry: got ir=%b valids=%b sum=%h, want ir=1 valids=1000 sum=00000002",
                  bus.in_ready, dut.v_q, bus.sum);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         n_cmp++;
         if ({dut.v_q, bus.sum} !== {exp_c[i], 32'h00000002}) begin
            n_err++;
            $display("FAIL collapse_%0d: got valids=%b sum=%h, want valids=%b sum=00000002",
                     i, dut.v_q, bus.sum, exp_c[i]);
         end
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      n_cmp++;
      if ({dut.v_q, bus.sum} !== {4'b1000, 32'h00000004}) begin
         n_err++;
         $display("FAIL collapse_next: got valids=%b sum=%h, want valids=1000 sum=00000004", dut.v_q, bus.sum);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_stream();
      res_t q[$];
      res_t exp_r;
      res_t held;
      logic stall_prev;
      logic [32:0] full;
      logic [31:0] be;
      int sent;
      int got;
      int cyc;
      stall_prev = 1'b0;
      held = '0;
      sent = 0;
      got  = 0;
      cyc  = 0;
      while ((sent < 100 || q.size() > 0) && cyc < 3000) begin
         bus.out_ready = ($urandom_range(0, 9) > 3);
         if (sent < 100) begin
            bus.in_valid = 1'b1;
            bus.a   = $urandom;
            bus.b   = $urandom;
            bus.cin = 1'($urandom_range(0, 1));
            bus.sub = 1'($urandom_range(0, 1));
         end else begin
            bus.in_valid = 1'b0;
         end
         #1;
         if (stall_prev) begin
            n_cmp++;
            if ({bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.zero} !== {1'b1, held}) begin
               n_err++;
               $display("FAIL stall_hold: got ov=%b sum=%h c=%b v=%b z=%b, want ov=1 and held %h",
                        bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.zero, held);
            end
         end
         n_cmp++;
         if (bus.in_ready !== ((q.size() < STAGES) || bus.out_ready)) begin
            n_err++;
            $display("FAIL stream_ready: got in_ready=%b, want %b (in flight=%0d out_ready=%b)",
                     bus.in_ready, (q.size() < STAGES) || bus.out_ready, q.size(), bus.out_ready);
         end
         if (bus.out_valid) begin
            n_cmp++;
            if (q.size() == 0) begin
               n_err++;
               $display("FAIL stream_extra: got out_valid=1 sum=%h, want no result pending", bus.sum);
            end else if ({bus.sum, bus.cout, bus.ovf, bus.zero} !== q[0]) begin
               n_err++;
               $display("FAIL stream_data_%0d: got sum=%h c=%b v=%b z=%b, want %h/%b/%b/%b",
                        got, bus.sum, bus.cout, bus.ovf, bus.zero, q[0].s, q[0].co, q[0].ov, q[0].z);
            end
         end
         stall_prev = bus.out_valid & ~bus.out_ready;
         held = {bus.sum, bus.cout, bus.ovf, bus.zero};
         if (bus.out_valid && bus.out_ready && q.size() > 0) begin
            void'(q.pop_front());
            got++;
         end
         if (bus.in_valid && bus.in_ready) begin
            be   = bus.sub ? ~bus.b : bus.b;
            full = {1'b0, bus.a} + {1'b0, be} + {32'h0, bus.sub | bus.cin};
            exp_r.s  = full[31:0];
            exp_r.co = full[32];
            exp_r.ov = (bus.a[31] == be[31]) && (full[31] != bus.a[31]);
            exp_r.z  = (full[31:0] == 32'h0);
            q.push_back(exp_r);
            sent++;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      n_cmp++;
      if (sent !== 100 || got !== 100 || q.size() !== 0) begin
         n_err++;
         $display("FAIL stream_count: got sent=%0d received=%0d pending=%0d after %0d cycles, want 100/100/0",
                  sent, got, q.size(), cyc);
      end
   endtask

   task automatic test_reset_inflight();
      int cyc;
      logic seen;
      bus.out_ready = 1'b1;
      bus.sub = 1'b0;  bus.cin = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.a = 32'd100 + i;
         bus.b = 32'd1;
         bus.in_valid = 1'b1;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++;
      if ({bus.out_valid, bus.sum, dut.v_q} !== {1'b1, 32'h00000065, 4'b1110}) begin
         n_err++;
         $display("FAIL inflight_pre: got ov=%b sum=%h valids=%b, want ov=1 sum=00000065 valids=1110",
                  bus.out_valid, bus.sum, dut.v_q);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.zero, dut.v_q} !== {1'b0, 32'h0, 3'b000, 4'b0000}) begin
         n_err++;
         $display("FAIL inflight_reset: got ov=%b sum=%h c=%b v=%b z=%b valids=%b, want all zero",
                  bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.zero, dut.v_q);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         seen = seen | bus.out_valid;
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_err++;
         $display("FAIL inflight_stale: got out_valid=1 after reset release, want none");
      end
      bus.a = 32'h0F0F0F0F;
      bus.b = 32'hF0F0F0F1;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      cyc = 0;
      while (!bus.out_valid && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      n_cmp++;
      if ({cyc == STAGES - 1, bus.sum, bus.cout, bus.ovf, bus.zero} !== {1'b1, 32'h0, 1'b1, 1'b0, 1'b1}) begin
         n_err++;
         $display("FAIL post_reset_txn: got edges=%0d sum=%h c=%b v=%b z=%b, want edges=3 sum=00000000 c=1 v=0 z=1",
                  cyc, bus.sum, bus.cout, bus.ovf, bus.zero);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.a   = '0;
      bus.b   = '0;
      bus.cin = 1'b0;
      bus.sub = 1'b0;
      test_reset();
      test_add();
      test_subtract();
      test_back_to_back();
      test_bubble();
      test_stream();
      test_reset_inflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor for the execute stage and multi-cycle arithmetic units. Operands are split into STAGES equal segments. Each pipeline stage resolves one segment with 4-bit lookahead groups and a group-level lookahead carry, then registers the carry into the next stage. A valid/ready handshake on both sides gives one result per cycle with full back-pressure.

Parameters:
WIDTH, 32, operand/result width in bits; must equal STAGES*SEG
STAGES, 4, pipeline depth and segment count; SEG = WIDTH/STAGES, SEG must be a multiple of 4
RESET_DATA, 0, value loaded into all data registers on reset

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand transaction valid
in_ready  output  1  block can accept an operand this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in; used only when sub=0
sub  input  1  1: compute a-b; 0: compute a+b+cin
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result
cout  output  1  carry-out of MSB; for sub, 1 = no borrow
ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB
zero  output  1  sum == 0

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n). All of the following apply on reset: every stage valid flag is 0; out_valid = 0; sum/cout/ovf/zero = RESET_DATA/0/0/0; in_ready = 1 once rst_n is high.
- Operand conditioning at acceptance: b_eff = sub ? ~b : b; c0 = sub ? 1 : cin.
- Stage k (0..STAGES-1) adds bits [k*SEG +: SEG] of a and b_eff with the carry from stage k-1 (c0 for k=0).
- Within a segment: 4-bit groups produce per-bit sums plus group G/P. Group carries come from the lookahead equations c(i+1) = G(i) | P(i)&c(i), expanded without ripple across groups. Segment carry-out is registered.
- Each stage register holds: valid bit, the already-computed low sum bits, the unprocessed high bits of a/b_eff, the carry, and the bit-(WIDTH-1) carry-in needed for ovf.
- Latency: a transaction accepted at edge N (in_valid & in_ready) presents out_valid=1 with its result after edge N+STAGES-1. Minimum latency is STAGES cycles from the presentation cycle; the last stage register is the output register.
- Handshake and advance rule:
  - adv[STAGES-1] = !v[STAGES-1] | out_ready
  - adv[k] = !v[k] | adv[k+1]
  - in_ready = adv[0], combinational from out_ready.
  - A stage loads when it advances. The loaded valid comes from the previous stage (or in_valid & in_ready for stage 0).
  - A non-advancing stage holds data and valid unchanged.
- Bubbles collapse: an empty stage accepts even while downstream is stalled.
- Throughput: 1 transaction/cycle while out_ready=1. Results leave in acceptance order, with none dropped or duplicated.
- Output stability: while out_valid=1 and out_ready=0, sum/cout/ovf/zero hold stable.
- Back-pressure: with all stages full and out_ready=0, in_ready=0. When out_ready rises, in_ready rises in the same cycle.
- Payload don't-care: a, b, cin and sub are ignored when in_valid=0 or in_ready=0.
- zero is computed from the final registered sum, not from a partial.
- Wrap-around: the sum is modulo 2^WIDTH, with the carry reported only on cout.
- Reset mid-operation: all in-flight transactions are discarded immediately, asynchronously. No result emerges after reset release.
- STAGES=1 degenerates to a single registered WIDTH-bit lookahead adder with the same handshake.

Test Plan:
1. WIDTH=32, STAGES=4, sub=0, a=0xFFFFFFFF, b=0x00000001, cin=0 -> out_valid 4 cycles later; sum=0x00000000, cout=1, zero=1, ovf=0.
2. a=0x7FFFFFFF, b=0x00000001, sub=0 -> sum=0x80000000, cout=0, ovf=1, zero=0. Separately, a=0x0000FFFF, b=0x1 -> sum=0x00010000, proving the carry crosses segment boundaries.
3. sub=1, a=5, b=7, cin=1 (ignored) -> sum=0xFFFFFFFE, cout=0, ovf=0. Separately, sub=1, a=7, b=5 -> sum=0x00000002, cout=1.
4. Stream 100 random transactions with in_valid=1 while out_ready toggles pseudo-randomly. Results match the reference model in order, with none lost. in_ready=0 only when all 4 stages are full and out_ready=0; outputs are stable during the stall.
5. Fill the pipe with out_ready=0, then assert out_ready -> in_ready goes high the same cycle and 4 results drain on consecutive cycles. Bubble test: an isolated transaction followed by idle cycles -> each intermediate stage is entered for exactly one cycle.
6. Assert rst_n low for 1 cycle with 3 transactions in flight -> out_valid=0 immediately, sum=RESET_DATA, and no stale result afterwards. The first post-reset transaction completes with the correct value after 4 cycles.
